// File: rtl/sobel_result_packer.sv
// Packs four 16-bit Sobel magnitude pixels MSB-first into 64-bit words and
// writes them to consecutive word addresses through a one-deep output register.
module sobel_result_packer #(
  parameter int unsigned STARTADDRESS = 0,
  parameter int unsigned ENDADDRESS   = 1048575,
  parameter int unsigned ADDRW        = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [15:0]      pix_data,
  output logic             pix_ready,
  input  logic             frame_end,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [ADDRW-1:0] wr_addr,
  output logic [63:0]      wr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  localparam logic [ADDRW-1:0] START_A = ADDRW'(STARTADDRESS);
  localparam logic [ADDRW-1:0] END_A   = ADDRW'(ENDADDRESS);

  state_t      state;
  logic [1:0]  lane;
  logic [47:0] asm_word;
  logic        pix_xfer;
  logic        wr_xfer;
  logic        last_wr;
  logic        out_free;

  assign pix_ready = (state == PACK) && !(lane == 2'd3 && wr_valid && !wr_ready);
  assign pix_xfer  = pix_valid && pix_ready;
  assign wr_xfer   = wr_valid && wr_ready;
  assign last_wr   = wr_xfer && (wr_addr == END_A);
  assign out_free  = !wr_valid || wr_xfer;
  assign busy      = (state == PACK) || (state == FLUSH);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lane     <= '0;
      asm_word <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= START_A;
      wr_data  <= '0;
    end else begin
      // A drain and a reload on the same edge: the reload below wins.
      if (wr_xfer) begin
        wr_valid <= 1'b0;
        wr_addr  <= wr_addr + ADDRW'(1);
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= PACK;
            lane     <= '0;
            asm_word <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= START_A;
          end
        end
        PACK: begin
          if (pix_xfer) begin
            if (lane == 2'd3) begin
              // The frame is already full when the last word drains now.
              if (!last_wr) begin
                wr_data  <= {asm_word, pix_data};
                wr_valid <= 1'b1;
              end
              asm_word <= '0;
              lane     <= '0;
            end else begin
              case (lane)
                2'd0:    asm_word[47:32] <= pix_data;
                2'd1:    asm_word[31:16] <= pix_data;
                default: asm_word[15:0]  <= pix_data;
              endcase
              lane <= lane + 2'd1;
            end
          end
          if (last_wr)
            state <= DONE;
          else if (frame_end)
            state <= FLUSH;
        end
        FLUSH: begin
          if (last_wr) begin
            state <= DONE;
          end else if (lane != 2'd0) begin
            // Unfilled lanes are already zero since asm_word clears per word.
            if (out_free) begin
              wr_data  <= {asm_word, 16'h0000};
              wr_valid <= 1'b1;
              asm_word <= '0;
              lane     <= '0;
            end
          end else if (out_free) begin
            state <= DONE;
          end
        end
      endcase
    end
  end

endmodule
